// File: rtl/vga_timing_pkg.sv
// Shared definitions for the VGA/SVGA raster timing generator.
//
// Contents:
//   run_state_t      - run/idle state of the generator
//   timing_mode_t    - one complete set of raster timing values
//   VGA_640x480_60   - 640x480 @ 60 Hz, negative sync polarity
//   SVGA_800x600_60  - 800x600 @ 60 Hz, positive sync polarity
//   clog2()          - bits needed to count 0..value-1, used in width checks
package vga_timing_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_t;

  typedef struct packed {
    int   h_active;
    int   h_fp;
    int   h_sync;
    int   h_bp;
    int   v_active;
    int   v_fp;
    int   v_sync;
    int   v_bp;
    logic hs_pol;
    logic vs_pol;
  } timing_mode_t;

  localparam timing_mode_t VGA_640x480_60 = '{
    h_active: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,   v_bp: 33,
    hs_pol: 1'b0, vs_pol: 1'b0
  };

  localparam timing_mode_t SVGA_800x600_60 = '{
    h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
    v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
    hs_pol: 1'b1, vs_pol: 1'b1
  };

  // Number of bits needed to represent value-1 (0 for value <= 1).
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/vga_timing_gen_axis.sv
// timing_axis: one raster axis (horizontal or vertical) of the timing generator.
//
// A wrap counter over ACTIVE+FP+SYNC+BP positions with a registered sync
// output derived from the same next value as the count, so count and sync
// always change together.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clr          force the axis to its idle position (count 0, sync inactive)
//   inc          advance one position this edge (wraps after the last one)
//   count        registered position
//   sync         registered sync level, POL while in the sync window
//   at_last      current count is the last position (drives the next axis)
//   count_next   position that will be loaded on this edge
//   active_next  position being loaded is visible and the axis is not idle
//   first_next   position being loaded is 0
//   last_next    position being loaded is the last one
module timing_axis
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = 800,
  parameter int FP     = 40,
  parameter int SYNC   = 128,
  parameter int BP     = 88,
  parameter bit POL    = 1'b1,
  parameter int W      = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         sync,
  output logic         at_last,
  output logic [W-1:0] count_next,
  output logic         active_next,
  output logic         first_next,
  output logic         last_next
);

  localparam int TOTAL      = ACTIVE + FP + SYNC + BP;
  localparam int SYNC_START = ACTIVE + FP;
  localparam int SYNC_END   = ACTIVE + FP + SYNC;
  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  // Bad parameter sets must stop elaboration rather than produce a
  // silently wrong raster.
  generate
    if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_timing
      $error("timing_axis: ACTIVE, FP, SYNC and BP must all be >= 1");
    end
    if (W < 1 || W > 31 || clog2(TOTAL) > W) begin : g_bad_width
      $error("timing_axis: counter width W cannot hold TOTAL-1");
    end
  endgenerate

  logic sync_next;

  assign at_last = (count == LAST);

  always_comb begin
    count_next = count;
    if (clr) begin
      count_next = '0;
    end else if (inc) begin
      count_next = at_last ? '0 : count + W'(1);
    end
  end

  // Window compares are done at 32 bits against the full parameter values
  // so nothing is truncated to the counter width.
  always_comb begin
    sync_next   = ((32'(count_next) >= SYNC_START) && (32'(count_next) < SYNC_END)) ? POL : ~POL;
    active_next = ~clr && (32'(count_next) < ACTIVE);
    first_next  = (count_next == '0);
    last_next   = (count_next == LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      sync  <= ~POL;
    end else begin
      count <= count_next;
      sync  <= sync_next;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA/SVGA raster timing generator.
//
// Combines a horizontal and a vertical timing_axis, adds run/idle control,
// a pixel clock enable, data enable and one-clock line/frame markers.
// Every output is a register loaded from the same next-position values, so
// sync, de and the markers always describe the hcount/vcount shown in the
// same cycle.
//
// Ports:
//   clk          pixel-domain clock
//   rst          asynchronous active-high reset
//   ce           pixel enable; the position moves only on edges with ce=1
//   en           run control; 0 forces idle on any edge
//   hcount       current column, 0..H_TOTAL-1
//   vcount       current line, 0..V_TOTAL-1
//   hsync        horizontal sync, active level HS_POL
//   vsync        vertical sync, active level VS_POL
//   de           data enable (visible region while running)
//   line_start   pulse when a position with hcount=0 is loaded
//   frame_start  pulse when position (0,0) is loaded
//   line_end     pulse when hcount=H_TOTAL-1 is loaded
//   frame_end    pulse when (H_TOTAL-1, V_TOTAL-1) is loaded
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int HW       = 11,
  parameter int VW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          en,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          line_start,
  output logic          frame_start,
  output logic          line_end,
  output logic          frame_end
);

  run_state_t state, state_next;

  logic          running;
  logic          clr;
  logic          load;
  logic          h_inc;
  logic          v_inc;
  logic          h_at_last;
  logic          v_at_last;
  logic [HW-1:0] h_count_next;
  logic [VW-1:0] v_count_next;
  logic          h_active_next;
  logic          v_active_next;
  logic          h_first_next;
  logic          v_first_next;
  logic          h_last_next;
  logic          v_last_next;

  // Run/idle state: idle leaves on the first qualified edge with en=1,
  // and en=0 returns to idle on any edge, ce or not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (en && ce) state_next = ST_RUN;
      ST_RUN:  if (!en) state_next = ST_IDLE;
    endcase
  end

  assign running = (state == ST_RUN);
  // Both axes are held at their idle position whenever the next state is
  // idle; this covers en=0 as well as en=1 with no ce yet.
  assign clr     = (state_next == ST_IDLE);
  // A qualified edge either loads (0,0) from idle or advances one pixel;
  // in both cases a new position is presented and markers may fire.
  assign load    = en && ce;
  // From idle the axes already sit at 0, so the first qualified edge
  // presents (0,0) without incrementing.
  assign h_inc   = running && ce;
  assign v_inc   = h_at_last && h_inc;

  timing_axis #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HS_POL),
    .W      (HW)
  ) u_h_axis (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .inc         (h_inc),
    .count       (hcount),
    .sync        (hsync),
    .at_last     (h_at_last),
    .count_next  (h_count_next),
    .active_next (h_active_next),
    .first_next  (h_first_next),
    .last_next   (h_last_next)
  );

  timing_axis #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VS_POL),
    .W      (VW)
  ) u_v_axis (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .inc         (v_inc),
    .count       (vcount),
    .sync        (vsync),
    .at_last     (v_at_last),
    .count_next  (v_count_next),
    .active_next (v_active_next),
    .first_next  (v_first_next),
    .last_next   (v_last_next)
  );

  // The raw next counts are already folded into the first/last/active
  // flags; they stay visible here only for debug probing.
  logic unused_bits;
  assign unused_bits = ^{h_count_next, v_count_next, v_at_last};

  // Markers are gated by load so they are exactly one clk wide and never
  // appear on a ce=0 edge, however sparse ce is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      line_end    <= 1'b0;
      frame_end   <= 1'b0;
    end else begin
      de          <= h_active_next && v_active_next;
      line_start  <= load && h_first_next;
      frame_start <= load && h_first_next && v_first_next;
      line_end    <= load && h_last_next;
      frame_end   <= load && h_last_next && v_last_next;
    end
  end

endmodule
